// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: size codes, response record, lane rules.
// Pure declarations; no timing or flow-control behaviour of its own.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct packed {
        logic       vld;
        logic       owner;
        logic       we;
        logic [1:0] size;
        logic [1:0] off;
        logic       uns;
        logic       err;
    } rsp_t;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte-selects and replicated data, load extract with sign/zero extension.
// Zero latency, no flow control; used on both the issue side and the response side.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  bytesel_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = rdata_i[{off_i, 3'b000} +: 8];
        half_sel    = rdata_i[{off_i[1], 4'b0000} +: 16];
        err_o       = access_err(size_i, off_i);
        bytesel_o   = lane_mask(size_i, off_i);
        wdata_rep_o = wdata_i;
        rdata_ext_o = '0;
        case (size_i)
            SZ_B: begin
                wdata_rep_o = {4{wdata_i[7:0]}};
                rdata_ext_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                wdata_rep_o = {2{wdata_i[15:0]}};
                rdata_ext_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            end
            SZ_W:    rdata_ext_o = rdata_i;
            default: rdata_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of a byte-laned data memory.
// Grant is combinational and issues every cycle a request is present; response one cycle after grant, no stall.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH+1:0] p0_addr,
    input  logic [1:0]            p0_size,
    input  logic                  p0_unsigned,
    input  logic [31:0]           p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [31:0]           p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH+1:0] p1_addr,
    input  logic [1:0]            p1_size,
    input  logic                  p1_unsigned,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [31:0]           p1_rdata,
    output logic                  p1_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [3:0]            mem_bytesel,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    logic                  prio_q, prio_d;
    rsp_t                  rsp_q, rsp_d;

    logic                  any_gnt, issue;
    logic                  sel_we, sel_uns;
    logic [ADDR_WIDTH+1:0] sel_addr;
    logic [1:0]            sel_size;
    logic [31:0]           sel_wdata;
    logic                  iss_err;
    logic [3:0]            iss_bytesel;
    logic [31:0]           iss_wdata;
    logic [31:0]           rsp_ext, rsp_data;

    logic [31:0]           unused_iss_rdata;
    logic [3:0]            unused_rsp_bytesel;
    logic [31:0]           unused_rsp_wdata;
    logic                  unused_rsp_err;

    // Grants are held off while reset is asserted so every output reads 0 during reset.
    assign p0_gnt  = ~rst & p0_req & (~p1_req | ~prio_q);
    assign p1_gnt  = ~rst & p1_req & (~p0_req |  prio_q);
    assign any_gnt = p0_gnt | p1_gnt;

    assign sel_we    = p1_gnt ? p1_we       : p0_we;
    assign sel_uns   = p1_gnt ? p1_unsigned : p0_unsigned;
    assign sel_addr  = p1_gnt ? p1_addr     : p0_addr;
    assign sel_size  = p1_gnt ? p1_size     : p0_size;
    assign sel_wdata = p1_gnt ? p1_wdata    : p0_wdata;

    dmem_lane_align u_issue_align (
        .size_i      (sel_size),
        .off_i       (sel_addr[1:0]),
        .uns_i       (sel_uns),
        .wdata_i     (sel_wdata),
        .rdata_i     (32'h0),
        .bytesel_o   (iss_bytesel),
        .wdata_rep_o (iss_wdata),
        .rdata_ext_o (unused_iss_rdata),
        .err_o       (iss_err)
    );

    // Faulting requests are still granted and answered, but never touch the memory.
    assign issue       = any_gnt & ~iss_err;
    assign mem_we      = issue & sel_we;
    assign mem_re      = issue & ~sel_we;
    assign mem_bytesel = issue ? iss_bytesel : 4'b0000;
    assign mem_wdata   = (issue & sel_we) ? iss_wdata : 32'h0;
    assign mem_addr    = any_gnt ? sel_addr[ADDR_WIDTH+1:2] : '0;

    always_comb begin
        prio_d = prio_q;
        if (p0_gnt) begin
            prio_d = 1'b1;
        end else if (p1_gnt) begin
            prio_d = 1'b0;
        end
        rsp_d.vld   = any_gnt;
        rsp_d.owner = p1_gnt;
        rsp_d.we    = sel_we;
        rsp_d.size  = sel_size;
        rsp_d.off   = sel_addr[1:0];
        rsp_d.uns   = sel_uns;
        rsp_d.err   = iss_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
            rsp_q  <= '0;
        end else begin
            prio_q <= prio_d;
            rsp_q  <= rsp_d;
        end
    end

    dmem_lane_align u_rsp_align (
        .size_i      (rsp_q.size),
        .off_i       (rsp_q.off),
        .uns_i       (rsp_q.uns),
        .wdata_i     (32'h0),
        .rdata_i     (mem_rdata),
        .bytesel_o   (unused_rsp_bytesel),
        .wdata_rep_o (unused_rsp_wdata),
        .rdata_ext_o (rsp_ext),
        .err_o       (unused_rsp_err)
    );

    assign rsp_data  = (rsp_q.we | rsp_q.err) ? 32'h0 : rsp_ext;

    assign p0_rvalid = rsp_q.vld & ~rsp_q.owner;
    assign p1_rvalid = rsp_q.vld &  rsp_q.owner;
    assign p0_rdata  = p0_rvalid ? rsp_data : 32'h0;
    assign p1_rdata  = p1_rvalid ? rsp_data : 32'h0;
    assign p0_err    = p0_rvalid & rsp_q.err;
    assign p1_err    = p1_rvalid & rsp_q.err;

endmodule
